fp16_mul_pipe: RTL and testbench

Three-stage pipelined IEEE-754 half-precision multiplier with valid/ready handshaking. It sits directly upstream of the fp16 adder in the neuron datapath and produces the weight × activation products that the adder accumulates. Rounding, subnormal and special-value handling are matched to the adder, so products feed it without reformatting.

---
 rtl/fp16_mul_pipe.sv | 156 +++++++++++++++
 tb/tb_fp16_mul_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_mul_pipe.sv
// Three-stage pipelined fp16 multiplier (decode, multiply, normalize/pack).
// Inputs are flushed to zero, results are truncated, and every stage stalls together when the output is blocked.
module fp16_mul_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_result,
    output logic        out_last,
    output logic        out_overflow,
    output logic        out_underflow,
    output logic        out_nan,
    output logic        out_valid,
    input  logic        out_ready
);

    logic              stall_s;
    logic              a_nan_s, a_inf_s, a_zero_s;
    logic              b_nan_s, b_inf_s, b_zero_s;
    logic              cls_nan_s, cls_inf_s, cls_zero_s;
    logic signed [6:0] exp_sum_s;

    logic              s1_valid_r, s1_last_r, s1_sign_r, s1_nan_r, s1_inf_r, s1_zero_r;
    logic signed [6:0] s1_exp_r;
    logic [10:0]       s1_ma_r, s1_mb_r;

    logic              s2_valid_r, s2_last_r, s2_sign_r, s2_nan_r, s2_inf_r, s2_zero_r;
    logic signed [6:0] s2_exp_r;
    logic [11:0]       s2_prod_r;  // bits [21:10] of the mantissa product; lower bits are truncated away

    logic signed [6:0] exp_norm_s;
    logic [9:0]        frac_s;
    logic [15:0]       res_s;
    logic              ovf_s, unf_s, nan_s;

    assign stall_s  = out_valid && !out_ready;
    assign in_ready = !stall_s && !rst;

    // Classify operands and form the biased exponent sum.
    always_comb begin
        a_nan_s    = (in_a[14:10] == 5'd31) && (in_a[9:0] != 10'd0);
        a_inf_s    = (in_a[14:10] == 5'd31) && (in_a[9:0] == 10'd0);
        a_zero_s   = (in_a[14:10] == 5'd0);
        b_nan_s    = (in_b[14:10] == 5'd31) && (in_b[9:0] != 10'd0);
        b_inf_s    = (in_b[14:10] == 5'd31) && (in_b[9:0] == 10'd0);
        b_zero_s   = (in_b[14:10] == 5'd0);
        cls_nan_s  = a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s);
        cls_inf_s  = a_inf_s || b_inf_s;
        cls_zero_s = a_zero_s || b_zero_s;
        exp_sum_s  = $signed({2'b00, in_a[14:10]} + {2'b00, in_b[14:10]} - 7'd15);
    end

    // Stage 1 register: decoded operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_nan_r   <= 1'b0;
            s1_inf_r   <= 1'b0;
            s1_zero_r  <= 1'b0;
            s1_exp_r   <= 7'sd0;
            s1_ma_r    <= 11'd0;
            s1_mb_r    <= 11'd0;
        end else if (!stall_s) begin
            s1_valid_r <= in_valid;
            s1_last_r  <= in_last;
            s1_sign_r  <= in_a[15] ^ in_b[15];
            s1_nan_r   <= cls_nan_s;
            s1_inf_r   <= cls_inf_s;
            s1_zero_r  <= cls_zero_s;
            s1_exp_r   <= exp_sum_s;
            s1_ma_r    <= {1'b1, in_a[9:0]};
            s1_mb_r    <= {1'b1, in_b[9:0]};
        end
    end

    // Stage 2 register: mantissa product with class, sign and exponent carried along.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_last_r  <= 1'b0;
            s2_sign_r  <= 1'b0;
            s2_nan_r   <= 1'b0;
            s2_inf_r   <= 1'b0;
            s2_zero_r  <= 1'b0;
            s2_exp_r   <= 7'sd0;
            s2_prod_r  <= 12'd0;
        end else if (!stall_s) begin
            s2_valid_r <= s1_valid_r;
            s2_last_r  <= s1_last_r;
            s2_sign_r  <= s1_sign_r;
            s2_nan_r   <= s1_nan_r;
            s2_inf_r   <= s1_inf_r;
            s2_zero_r  <= s1_zero_r;
            s2_exp_r   <= s1_exp_r;
            s2_prod_r  <= 12'((22'(s1_ma_r) * 22'(s1_mb_r)) >> 10);
        end
    end

    // Normalize, then resolve special values and range in priority order.
    always_comb begin
        exp_norm_s = s2_exp_r;
        frac_s     = s2_prod_r[9:0];
        res_s      = 16'h0000;
        ovf_s      = 1'b0;
        unf_s      = 1'b0;
        nan_s      = 1'b0;
        if (s2_prod_r[11]) begin
            exp_norm_s = s2_exp_r + 7'sd1;
            frac_s     = s2_prod_r[10:1];
        end else begin
            exp_norm_s = s2_exp_r;
            frac_s     = s2_prod_r[9:0];
        end
        if (s2_nan_r) begin
            res_s = 16'h7E00;
            nan_s = 1'b1;
        end else if (s2_inf_r) begin
            res_s = {s2_sign_r, 15'h7C00};
        end else if (s2_zero_r) begin
            res_s = {s2_sign_r, 15'h0000};
        end else if (exp_norm_s >= 7'sd31) begin
            res_s = {s2_sign_r, 15'h7C00};
            ovf_s = 1'b1;
        end else if (exp_norm_s <= 7'sd0) begin
            res_s = {s2_sign_r, 15'h0000};
            unf_s = 1'b1;
        end else begin
            res_s = {s2_sign_r, exp_norm_s[4:0], frac_s};
        end
    end

    // Stage 3 register: the block outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            out_result    <= 16'h0000;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_nan       <= 1'b0;
        end else if (!stall_s) begin
            out_valid     <= s2_valid_r;
            out_last      <= s2_last_r;
            out_result    <= res_s;
            out_overflow  <= ovf_s;
            out_underflow <= unf_s;
            out_nan       <= nan_s;
        end
    end

endmodule

// File: tb/tb_fp16_mul_pipe.sv
// Bench for fp16_mul_pipe: directed vector table, backpressure and reset sequences,
// and a random stream checked against a truncating flush-to-zero reference.
module tb_fp16_mul_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_a, in_b;
    logic        in_last, in_valid, in_ready;
    logic [15:0] out_result;
    logic        out_last, out_overflow, out_underflow, out_nan, out_valid, out_ready;

    fp16_mul_pipe dut (
        .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready), .out_result(out_result),
        .out_last(out_last), .out_overflow(out_overflow), .out_underflow(out_underflow),
        .out_nan(out_nan), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        last;
        logic [15:0] res;
        logic        ovf;
        logic        unf;
        logic        nan;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        unf;
        logic        nan;
        logic        last;
        int          stamp;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    function automatic exp_t mk_exp(logic [15:0] res, logic ovf, logic unf, logic nan, logic lst, bit lat);
        exp_t e;
        e.res = res; e.ovf = ovf; e.unf = unf; e.nan = nan; e.last = lst;
        e.stamp = 0; e.chk_lat = lat;
        return e;
    endfunction

    // Reference: exact mantissa product, single normalization step, truncation.
    function automatic exp_t ref_mul(logic [15:0] a, logic [15:0] b, logic lst);
        int  ea, eb, ue, m;
        bit  an, ai, az, bn, bi, bz;
        logic s;
        logic [9:0] fr;
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        an = (ea == 31) && (a[9:0] != 10'd0); ai = (ea == 31) && (a[9:0] == 10'd0); az = (ea == 0);
        bn = (eb == 31) && (b[9:0] != 10'd0); bi = (eb == 31) && (b[9:0] == 10'd0); bz = (eb == 0);
        s  = a[15] ^ b[15];
        if (an || bn || (ai && bz) || (bi && az)) return mk_exp(16'h7E00, 1'b0, 1'b0, 1'b1, lst, 1'b0);
        if (ai || bi) return mk_exp({s, 15'h7C00}, 1'b0, 1'b0, 1'b0, lst, 1'b0);
        if (az || bz) return mk_exp({s, 15'h0000}, 1'b0, 1'b0, 1'b0, lst, 1'b0);
        m  = (1024 + int'(a[9:0])) * (1024 + int'(b[9:0]));
        ue = ea + eb - 15;
        if (m >= 2097152) begin
            m  = m / 2;
            ue = ue + 1;
        end
        fr = 10'((m / 1024) % 1024);
        if (ue >= 31) return mk_exp({s, 15'h7C00}, 1'b1, 1'b0, 1'b0, lst, 1'b0);
        if (ue <= 0)  return mk_exp({s, 15'h0000}, 1'b0, 1'b1, 1'b0, lst, 1'b0);
        return mk_exp({s, 5'(ue), fr}, 1'b0, 1'b0, 1'b0, lst, 1'b0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    // One clock cycle: drive inputs, check any output transfer, record any input transfer.
    task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b, input logic lst,
                        input logic ordy, input exp_t e, output logic acc);
        exp_t h;
        in_valid = iv; in_a = a; in_b = b; in_last = lst; out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: got %h at cycle %0d, required no output", out_result, cyc);
            end else begin
                h = sb.pop_front();
                if ({out_result, out_overflow, out_underflow, out_nan, out_last} !==
                    {h.res, h.ovf, h.unf, h.nan, h.last} || (h.chk_lat && cyc != h.stamp + 3)) begin
                    n_bad++;
                    $display("FAIL product: got %h ovf=%b unf=%b nan=%b last=%b cycle %0d, required %h ovf=%b unf=%b nan=%b last=%b cycle %0d",
                             out_result, out_overflow, out_underflow, out_nan, out_last, cyc,
                             h.res, h.ovf, h.unf, h.nan, h.last, h.stamp + 3);
                end
            end
        end
        acc = iv && in_ready;
        if (acc) begin
            h = e;
            h.stamp = cyc;
            sb.push_back(h);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        logic acc;
        for (int k = 0; k < 20 && sb.size() > 0; k++)
            step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, mk_exp(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), acc);
        chk("drain_empty", sb.size(), 0);
    endtask

    vec_t        tbl[21];
    logic [15:0] bp_a[5];
    logic        bp_l[5];

    initial begin
        logic        acc;
        int          idx, j, accepted, guard;
        logic [15:0] ra, rb;
        logic        rl;

        tbl = '{
            '{16'h3C00, 16'h4000, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b0},
            '{16'h3E00, 16'h3E00, 1'b1, 16'h4080, 1'b0, 1'b0, 1'b0},
            '{16'hC200, 16'h3800, 1'b0, 16'hBE00, 1'b0, 1'b0, 1'b0},
            '{16'h7BFF, 16'h4000, 1'b1, 16'h7C00, 1'b1, 1'b0, 1'b0},
            '{16'h7C00, 16'h0000, 1'b0, 16'h7E00, 1'b0, 1'b0, 1'b1},
            '{16'hFC00, 16'h3C00, 1'b1, 16'hFC00, 1'b0, 1'b0, 1'b0},
            '{16'h0400, 16'h3800, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0},
            '{16'h8000, 16'h3C00, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0},
            '{16'h0001, 16'h3C00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0},
            '{16'h7E00, 16'h3C00, 1'b1, 16'h7E00, 1'b0, 1'b0, 1'b1},
            '{16'h0000, 16'hFC00, 1'b0, 16'h7E00, 1'b0, 1'b0, 1'b1},
            '{16'h7BFF, 16'h3BFF, 1'b1, 16'h7BFE, 1'b0, 1'b0, 1'b0},
            '{16'h7800, 16'h3C00, 1'b0, 16'h7800, 1'b0, 1'b0, 1'b0},
            '{16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0},
            '{16'hFC00, 16'hC000, 1'b0, 16'h7C00, 1'b0, 1'b0, 1'b0},
            '{16'h4000, 16'h4000, 1'b1, 16'h4400, 1'b0, 1'b0, 1'b0},
            '{16'h0400, 16'h3C00, 1'b0, 16'h0400, 1'b0, 1'b0, 1'b0},
            '{16'h0400, 16'h3BFF, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0},
            '{16'h7800, 16'h4000, 1'b0, 16'h7C00, 1'b1, 1'b0, 1'b0},
            '{16'h3C00, 16'h7C00, 1'b1, 16'h7C00, 1'b0, 1'b0, 1'b0},
            '{16'hFE00, 16'hBC00, 1'b0, 16'h7E00, 1'b0, 1'b0, 1'b1}
        };
        bp_a = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500};
        bp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_a = 16'h0000; in_b = 16'h0000; in_last = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 0);
        chk("reset_outputs", {11'd0, out_result, out_last, out_overflow, out_underflow, out_nan, out_valid}, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", {31'd0, in_ready}, 1);

        // Directed table streamed back to back; first three cover the consecutive-output case.
        for (int i = 0; i < 21; i++) begin
            step(1'b1, tbl[i].a, tbl[i].b, tbl[i].last, 1'b1,
                 mk_exp(tbl[i].res, tbl[i].ovf, tbl[i].unf, tbl[i].nan, tbl[i].last, 1'b1), acc);
            chk("table_accept", {31'd0, acc}, 1);
        end
        drain();

        // Backpressure: five items offered while the output is blocked.
        idx = 0;
        for (int k = 0; k < 8; k++) begin
            j = (idx < 5) ? idx : 4;
            step(idx < 5, bp_a[j], 16'h3C00, bp_l[j], 1'b0,
                 mk_exp(bp_a[j], 1'b0, 1'b0, 1'b0, bp_l[j], 1'b0), acc);
            if (acc) idx++;
            if (k >= 3) chk("bp_output_stable", {15'd0, out_valid, out_result}, {15'd0, 1'b1, 16'h3C00});
        end
        chk("bp_accepted", idx, 3);
        chk("bp_in_ready_low", {31'd0, in_ready}, 0);
        for (int k = 0; k < 30 && idx < 5; k++) begin
            step(1'b1, bp_a[idx], 16'h3C00, bp_l[idx], 1'b1,
                 mk_exp(bp_a[idx], 1'b0, 1'b0, 1'b0, bp_l[idx], 1'b0), acc);
            if (acc) idx++;
        end
        chk("bp_all_sent", idx, 5);
        drain();

        // Reset with two items in flight; neither may ever emerge.
        step(1'b1, 16'h4000, 16'h4000, 1'b1, 1'b1, mk_exp(16'h4400, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), acc);
        step(1'b1, 16'h4200, 16'h4000, 1'b1, 1'b1, mk_exp(16'h4600, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), acc);
        rst = 1'b1;
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, mk_exp(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), acc);
        chk("rst_mid_in_ready", {31'd0, in_ready}, 0);
        rst = 1'b0;
        sb.delete();
        chk("rst_mid_outputs", {11'd0, out_result, out_last, out_overflow, out_underflow, out_nan, out_valid}, 0);
        #1;
        chk("rst_mid_in_ready_after", {31'd0, in_ready}, 1);
        for (int k = 0; k < 6; k++)
            step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, mk_exp(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), acc);
        step(1'b1, 16'h3C00, 16'h4000, 1'b1, 1'b1, mk_exp(16'h4000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), acc);
        chk("rst_new_accept", {31'd0, acc}, 1);
        drain();

        // Random regression with random gaps and random backpressure.
        accepted = 0;
        guard    = 0;
        while (accepted < 10000 && guard < 60000) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ra[14:10] = 5'($urandom_range(8, 22));
            if ($urandom_range(0, 3) == 0) rb[14:10] = 5'($urandom_range(8, 22));
            rl = 1'($urandom_range(0, 1));
            step($urandom_range(0, 9) < 8, ra, rb, rl, $urandom_range(0, 9) < 7, ref_mul(ra, rb, rl), acc);
            if (acc) accepted++;
            guard++;
        end
        chk("random_count", accepted, 10000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
